// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
// The loader FSM states and header framing constants live here.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES = 4;

    // Image length must be a whole number of 32-bit instruction words.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b00;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory over a byte
// port and holds the CPU in reset until the whole image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_BYTES = 1000001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_LEN = MAX_BYTES[31:0];

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  hdr_cnt;
    logic [31:0] byte_cnt;
    logic [31:0] len;

    logic        xfer;
    logic        hdr_last;
    logic        data_last;
    logic [31:0] len_full;
    logic        restart;

    assign xfer      = s_valid && s_ready;
    assign hdr_last  = (hdr_cnt == 2'(HDR_BYTES - 1));
    assign data_last = (byte_cnt == len - 32'd1);
    // The final header byte is still on the bus, so the length is judged
    // from the assembled word rather than the register.
    assign len_full  = {s_data, len[23:0]};
    assign restart   = start && (state == IDLE || state == DONE || state == ERR);
    assign busy      = (state == LEN) || (state == DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                if (xfer && hdr_last) begin
                    if ((len_full > MAX_LEN) || (len_full[1:0] != WORD_ALIGN_MASK)) begin
                        state_nxt = ERR;
                    end else if (len_full == 32'd0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer && data_last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered off the next state so they line up with
    // the edge that enters each state, including done with the final write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            s_ready   <= (state_nxt == LEN) || (state_nxt == DATA);
            done      <= (state_nxt == DONE);
            error     <= (state_nxt == ERR);
            cpu_rst_n <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cnt  <= 2'd0;
            byte_cnt <= 32'd0;
            len      <= 32'd0;
        end else if (restart) begin
            hdr_cnt  <= 2'd0;
            byte_cnt <= 32'd0;
            len      <= 32'd0;
        end else if (xfer && state == LEN) begin
            case (hdr_cnt)
                2'd0:    len[7:0]   <= s_data;
                2'd1:    len[15:8]  <= s_data;
                2'd2:    len[23:16] <= s_data;
                default: len[31:24] <= s_data;
            endcase
            hdr_cnt <= hdr_cnt + 2'd1;
        end else if (xfer && state == DATA) begin
            byte_cnt <= byte_cnt + 32'd1;
        end
    end

    // Each accepted payload byte becomes a single-cycle write one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 8'd0;
        end else begin
            mem_we <= 1'b0;
            if (xfer && state == DATA) begin
                mem_we    <= 1'b1;
                mem_addr  <= BASE_ADDR + byte_cnt;
                mem_wdata <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: each scenario task drives a
// byte stream and compares writes and status against hand-computed values.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          wr_cyc[$];
    logic        wr_done[$];
    logic        wr_cpu[$];
    int          acc_cyc[$];

    imem_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_BYTES(1000001)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor samples on the falling edge, clear of the update edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
            wr_done.push_back(done);
            wr_cpu.push_back(cpu_rst_n);
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        wr_done.delete();
        wr_cpu.delete();
        acc_cyc.delete();
    endtask

    task automatic pulse_start();
        s_valid = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (t >= 20) begin
            failures++;
            $display("[TB] FAIL handshake_timeout: s_ready=%b required 1 for byte %h", s_ready, b);
        end
        @(posedge clk); #1;
        acc_cyc.push_back(cyc);
        if (gap) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [46:0] obs;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        #2;
        obs = {s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, error};
        checks++;
        if (obs !== 47'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h required 0", obs);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({s_ready, busy, cpu_rst_n, done} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: ready/busy/cpu/done=%b required 0000",
                     {s_ready, busy, cpu_rst_n, done});
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] img[12] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'h6F, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_d[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        clear_log();
        pulse_start();
        checks++;
        if ({s_ready, busy} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL basic_enter_len: ready/busy=%b required 11", {s_ready, busy});
        end
        for (int i = 0; i < 12; i++) push_byte(img[i], 1'b0);
        s_valid = 1'b0;
        checks++;
        if ({mem_we, done, cpu_rst_n} !== 3'b111) begin
            failures++;
            $display("[TB] FAIL basic_final_concurrent: we/done/cpu=%b required 111",
                     {mem_we, done, cpu_rst_n});
        end
        idle_cycles(3);
        checks++;
        if (wr_addr.size() != 8) begin
            failures++;
            $display("[TB] FAIL basic_write_count: got %0d required 8", wr_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wr_addr[i] !== 32'(i) || wr_data[i] !== exp_d[i] ||
                    wr_cyc[i] != wr_cyc[0] + i || wr_done[i] !== (i == 7) || wr_cpu[i] !== (i == 7)) begin
                    failures++;
                    $display("[TB] FAIL basic_write_%0d: addr=%h data=%h cyc=%0d done=%b cpu=%b required addr=%h data=%h cyc=%0d done/cpu=%b",
                             i, wr_addr[i], wr_data[i], wr_cyc[i], wr_done[i], wr_cpu[i],
                             32'(i), exp_d[i], wr_cyc[0] + i, (i == 7));
                end
            end
        end
        checks++;
        if ({done, cpu_rst_n, s_ready, busy, error} !== 5'b11000) begin
            failures++;
            $display("[TB] FAIL basic_done_state: done/cpu/ready/busy/err=%b required 11000",
                     {done, cpu_rst_n, s_ready, busy, error});
        end
    endtask

    task automatic test_bad_header(input logic [31:0] hdr, input string tag);
        clear_log();
        pulse_start();
        for (int k = 0; k < 4; k++) push_byte(hdr[8*k +: 8], 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        checks++;
        if ({error, cpu_rst_n, s_ready, done, busy} !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL %s_err_state: err/cpu/ready/done/busy=%b required 10000",
                     tag, {error, cpu_rst_n, s_ready, done, busy});
        end
        checks++;
        if (wr_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_no_writes: got %0d writes required 0", tag, wr_addr.size());
        end
    endtask

    task automatic test_zero_length();
        clear_log();
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_error_cleared: error=%b required 0", error);
        end
        for (int k = 0; k < 4; k++) push_byte(8'h00, 1'b0);
        s_valid = 1'b0;
        checks++;
        if ({done, cpu_rst_n, s_ready, error} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL zero_done: done/cpu/ready/err=%b required 1100",
                     {done, cpu_rst_n, s_ready, error});
        end
        idle_cycles(2);
        checks++;
        if (wr_addr.size() != 0) begin
            failures++;
            $display("[TB] FAIL zero_no_writes: got %0d writes required 0", wr_addr.size());
        end
    endtask

    task automatic test_gapped();
        logic [7:0] img[8] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_log();
        pulse_start();
        for (int i = 0; i < 8; i++) push_byte(img[i], 1'b1);
        idle_cycles(2);
        checks++;
        if (wr_addr.size() != 4) begin
            failures++;
            $display("[TB] FAIL gap_write_count: got %0d required 4", wr_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[i] !== 32'(i) || wr_data[i] !== img[4+i] || wr_cyc[i] != acc_cyc[4+i]) begin
                    failures++;
                    $display("[TB] FAIL gap_write_%0d: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i], 32'(i), img[4+i], acc_cyc[4+i]);
                end
            end
        end
        checks++;
        if ({done, cpu_rst_n} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL gap_done: done/cpu=%b required 11", {done, cpu_rst_n});
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] img[12] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                8'h05, 8'h06, 8'h07, 8'h08};
        pulse_start();
        for (int i = 0; i < 6; i++) push_byte(img[i], 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, error} !== 47'd0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: ready=%b we=%b addr=%h data=%h cpu=%b busy=%b required all 0",
                     s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_log();
        pulse_start();
        for (int i = 0; i < 12; i++) push_byte(img[i], 1'b0);
        idle_cycles(2);
        checks++;
        if (wr_addr.size() != 8) begin
            failures++;
            $display("[TB] FAIL midreset_reload_count: got %0d required 8", wr_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wr_addr[i] !== 32'(i) || wr_data[i] !== img[4+i]) begin
                    failures++;
                    $display("[TB] FAIL midreset_write_%0d: addr=%h data=%h required addr=%h data=%h",
                             i, wr_addr[i], wr_data[i], 32'(i), img[4+i]);
                end
            end
        end
    endtask

    task automatic test_start_ignored_and_reload();
        logic [7:0] img[12] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13,
                                8'h14, 8'h15, 8'h16, 8'h17};
        logic [7:0] img2[8] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        bit early_cpu = 1'b0;
        clear_log();
        pulse_start();
        for (int i = 0; i < 7; i++) push_byte(img[i], 1'b0);
        pulse_start();
        checks++;
        if ({s_ready, busy, done} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL start_in_data: ready/busy/done=%b required 110", {s_ready, busy, done});
        end
        for (int i = 7; i < 12; i++) push_byte(img[i], 1'b0);
        idle_cycles(2);
        checks++;
        if (wr_addr.size() != 8 || wr_addr[7] !== 32'd7 || wr_data[7] !== 8'h17 ||
            wr_addr[3] !== 32'd3 || wr_data[3] !== 8'h13) begin
            failures++;
            $display("[TB] FAIL start_ignored_load: count=%0d required 8 with addr3=13 addr7=17", wr_addr.size());
        end
        clear_log();
        pulse_start();
        checks++;
        if ({cpu_rst_n, done, busy} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL reload_cpu_drop: cpu/done/busy=%b required 001", {cpu_rst_n, done, busy});
        end
        for (int i = 0; i < 7; i++) begin
            push_byte(img2[i], 1'b0);
            if (cpu_rst_n !== 1'b0) early_cpu = 1'b1;
        end
        checks++;
        if (early_cpu) begin
            failures++;
            $display("[TB] FAIL reload_cpu_early: cpu_rst_n rose before final byte, required 0");
        end
        push_byte(img2[7], 1'b0);
        s_valid = 1'b0;
        checks++;
        if ({cpu_rst_n, done} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL reload_done: cpu/done=%b required 11", {cpu_rst_n, done});
        end
        idle_cycles(2);
        checks++;
        if (wr_addr.size() != 4 || wr_addr[3] !== 32'd3 || wr_data[3] !== 8'hE4 || wr_data[0] !== 8'hE1) begin
            failures++;
            $display("[TB] FAIL reload_writes: count=%0d required 4 with E1..E4 at 0..3", wr_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_header(32'h0000_0006, "misaligned");
        test_bad_header(32'h000F_4244, "oversize");
        test_zero_length();
        test_gapped();
        test_reset_mid_load();
        test_start_ignored_and_reload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
